// File: rtl/i2c_arb_pkg.sv
// Shared definitions for the I2C request arbiter.
// State encoding, default bus-hang timeout and width helper.
package i2c_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_BUSY  = 2'd2
  } arb_state_e;

  localparam int unsigned TIMEOUT_DEF = 1000000;

  function automatic int unsigned arb_clog2(
    input int unsigned n
  );
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(n)) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/i2c_req_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request
// at or above ptr_i, wrapping modulo N.
module rr_pick #(
  parameter int unsigned N  = 2,
  parameter int unsigned PW = 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic          valid_o
);

  int unsigned idx;
  logic        found;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = int'(ptr_i) + k;
      if (idx >= N) idx = idx - N;
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

  assign valid_o = found;

endmodule

// File: rtl/i2c_req_arbiter.sv
// Shares one i2c_dri master between CH_NUM requesters:
// latched requests, round-robin grant held until done/timeout.
module i2c_req_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int unsigned CH_NUM  = 2,
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst_n,
  input  logic [CH_NUM-1:0]       ch_exec,
  input  logic [CH_NUM-1:0]       ch_bit_ctrl,
  input  logic [CH_NUM-1:0]       ch_rh_wl,
  input  logic [CH_NUM*16-1:0]    ch_addr,
  input  logic [CH_NUM*8-1:0]     ch_data_w,
  input  logic [CH_NUM*WIDTH-1:0] ch_reg_num,
  output logic [7:0]              ch_data_r,
  output logic [CH_NUM-1:0]       ch_done,
  output logic [CH_NUM-1:0]       ch_err,
  output logic                    i2c_exec,
  output logic                    i2c_bit_ctrl,
  output logic                    i2c_rh_wl,
  output logic [15:0]             i2c_addr,
  output logic [7:0]              i2c_data_w,
  output logic [WIDTH-1:0]        i2c_reg_num,
  input  logic [7:0]              i2c_data_r,
  input  logic                    i2c_done,
  output logic                    arb_busy,
  output logic [CH_NUM-1:0]       arb_grant
);

  localparam int unsigned PW =
    (arb_clog2(CH_NUM) < 1) ? 1 : arb_clog2(CH_NUM);
  localparam int unsigned CW =
    (arb_clog2(TIMEOUT) < 1) ? 1 : arb_clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [PW-1:0] IDX_LAST = PW'(CH_NUM - 1);

  arb_state_e        state_q;
  logic [CH_NUM-1:0] pend_q, pend_d;
  logic [PW-1:0]     ptr_q, ptr_nxt;
  logic [PW-1:0]     gidx_q;
  logic [CW-1:0]     cnt_q;
  logic [CH_NUM-1:0] grant_q;
  logic [CH_NUM-1:0] done_q;
  logic [CH_NUM-1:0] err_q;
  logic              exec_q;
  logic              bitc_q;
  logic              rhwl_q;
  logic [15:0]       addr_q;
  logic [7:0]        dw_q;
  logic [WIDTH-1:0]  rn_q;
  logic [7:0]        dr_q;

  logic [CH_NUM-1:0] pick_gnt;
  logic              pick_vld;

  logic [PW-1:0]     sel_idx;
  logic              sel_bitc;
  logic              sel_rhwl;
  logic [15:0]       sel_addr;
  logic [7:0]        sel_dw;
  logic [WIDTH-1:0]  sel_rn;

  logic              in_busy;
  logic              hit_done;
  logic              hit_to;
  logic              fin;

  rr_pick #(
    .N  (CH_NUM),
    .PW (PW)
  ) u_pick (
    .req_i   (pend_q),
    .ptr_i   (ptr_q),
    .gnt_o   (pick_gnt),
    .valid_o (pick_vld)
  );

  // One-hot select of the picked channel's fields
  always_comb begin
    sel_idx  = '0;
    sel_bitc = 1'b0;
    sel_rhwl = 1'b0;
    sel_addr = '0;
    sel_dw   = '0;
    sel_rn   = '0;
    for (int i = 0; i < int'(CH_NUM); i++) begin
      if (pick_gnt[i]) begin
        sel_idx  = PW'(i);
        sel_bitc = ch_bit_ctrl[i];
        sel_rhwl = ch_rh_wl[i];
        sel_addr = ch_addr[16*i +: 16];
        sel_dw   = ch_data_w[8*i +: 8];
        sel_rn   = ch_reg_num[WIDTH*i +: WIDTH];
      end
    end
  end

  assign in_busy  = (state_q == S_BUSY);
  assign hit_done = in_busy && i2c_done;
  assign hit_to   = in_busy && !i2c_done
                 && (cnt_q == CNT_LAST);
  assign fin      = hit_done || hit_to;

  // A new request on the finishing edge survives the clear
  assign pend_d = (pend_q & ~(fin ? grant_q : '0))
                | ch_exec;

  assign ptr_nxt = (gidx_q == IDX_LAST) ? '0
                 : gidx_q + PW'(1);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= S_IDLE;
      pend_q  <= '0;
      ptr_q   <= '0;
      gidx_q  <= '0;
      cnt_q   <= '0;
      grant_q <= '0;
      done_q  <= '0;
      err_q   <= '0;
      exec_q  <= 1'b0;
      bitc_q  <= 1'b0;
      rhwl_q  <= 1'b0;
      addr_q  <= '0;
      dw_q    <= '0;
      rn_q    <= '0;
      dr_q    <= '0;
    end else begin
      pend_q <= pend_d;
      done_q <= '0;
      err_q  <= '0;
      exec_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (pick_vld) begin
            grant_q <= pick_gnt;
            gidx_q  <= sel_idx;
            bitc_q  <= sel_bitc;
            rhwl_q  <= sel_rhwl;
            addr_q  <= sel_addr;
            dw_q    <= sel_dw;
            rn_q    <= sel_rn;
            exec_q  <= 1'b1;
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          cnt_q   <= '0;
          state_q <= S_BUSY;
        end
        S_BUSY: begin
          cnt_q <= cnt_q + CW'(1);
          if (fin) begin
            done_q  <= grant_q;
            err_q   <= hit_to ? grant_q : '0;
            if (hit_done) dr_q <= i2c_data_r;
            ptr_q   <= ptr_nxt;
            grant_q <= '0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ch_data_r    = dr_q;
  assign ch_done      = done_q;
  assign ch_err       = err_q;
  assign i2c_exec     = exec_q;
  assign i2c_bit_ctrl = bitc_q;
  assign i2c_rh_wl    = rhwl_q;
  assign i2c_addr     = addr_q;
  assign i2c_data_w   = dw_q;
  assign i2c_reg_num  = rn_q;
  assign arb_busy     = (state_q != S_IDLE);
  assign arb_grant    = grant_q;

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Directed bench for i2c_req_arbiter, CH_NUM=4,
// TIMEOUT=100: vector table plus multi-cycle sequences.
module tb_i2c_req_arbiter;

  localparam int CH = 4;
  localparam int W  = 8;
  localparam int TO = 100;

  logic          sys_clk = 1'b0;
  logic          sys_rst_n = 1'b0;
  logic [CH-1:0] ch_exec = '0;
  logic [CH-1:0] ch_bit_ctrl = '0;
  logic [CH-1:0] ch_rh_wl = '0;
  logic [CH*16-1:0] ch_addr = '0;
  logic [CH*8-1:0]  ch_data_w = '0;
  logic [CH*W-1:0]  ch_reg_num = '0;
  logic [7:0]    ch_data_r;
  logic [CH-1:0] ch_done;
  logic [CH-1:0] ch_err;
  logic          i2c_exec;
  logic          i2c_bit_ctrl;
  logic          i2c_rh_wl;
  logic [15:0]   i2c_addr;
  logic [7:0]    i2c_data_w;
  logic [W-1:0]  i2c_reg_num;
  logic [7:0]    i2c_data_r = 8'hEE;
  logic          i2c_done = 1'b0;
  logic          arb_busy;
  logic [CH-1:0] arb_grant;

  int checks = 0;
  int failures = 0;
  int exec_cnt = 0;

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) if (i2c_exec) exec_cnt <= exec_cnt + 1;

  i2c_req_arbiter #(
    .CH_NUM  (CH),
    .WIDTH   (W),
    .TIMEOUT (TO)
  ) dut (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .ch_exec      (ch_exec),
    .ch_bit_ctrl  (ch_bit_ctrl),
    .ch_rh_wl     (ch_rh_wl),
    .ch_addr      (ch_addr),
    .ch_data_w    (ch_data_w),
    .ch_reg_num   (ch_reg_num),
    .ch_data_r    (ch_data_r),
    .ch_done      (ch_done),
    .ch_err       (ch_err),
    .i2c_exec     (i2c_exec),
    .i2c_bit_ctrl (i2c_bit_ctrl),
    .i2c_rh_wl    (i2c_rh_wl),
    .i2c_addr     (i2c_addr),
    .i2c_data_w   (i2c_data_w),
    .i2c_reg_num  (i2c_reg_num),
    .i2c_data_r   (i2c_data_r),
    .i2c_done     (i2c_done),
    .arb_busy     (arb_busy),
    .arb_grant    (arb_grant)
  );

  typedef struct {
    int          ch;
    logic [15:0] addr;
    logic        rh;
    logic        bc;
    logic [7:0]  dw;
    logic [7:0]  rn;
    logic [7:0]  rd;
    int          dly;
    logic [3:0]  eg;
    logic [7:0]  edr;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic cycle();
    @(negedge sys_clk);
  endtask

  task automatic do_reset();
    sys_rst_n = 1'b0;
    ch_exec   = '0;
    i2c_done  = 1'b0;
    cycle();
    cycle();
    sys_rst_n = 1'b1;
    cycle();
  endtask

  task automatic pulse_exec(input logic [CH-1:0] m);
    ch_exec = m;
    cycle();
    ch_exec = '0;
  endtask

  task automatic wait_exec(input int budget, output int n);
    n = 0;
    while (!i2c_exec && n < budget) begin
      cycle();
      n++;
    end
    chk("exec_seen", 32'(i2c_exec), 1);
  endtask

  // Called on the ISSUE cycle; dly==0 means never answer
  task automatic serve(input int dly,
                       input logic [7:0] rd,
                       input logic [3:0] eg,
                       input logic [7:0] edr,
                       input logic [3:0] rp);
    int n;
    cycle();
    chk("exec_1pulse", 32'(i2c_exec), 0);
    chk("busy_in_xfer", 32'(arb_busy), 1);
    if (dly == 0) begin
      n = 0;
      while (ch_done == '0 && n < 300) begin
        cycle();
        n++;
      end
      chk("to_cycles", n, TO);
      chk("to_err", 32'(ch_err), 32'(eg));
    end else begin
      repeat (dly - 1) cycle();
      i2c_done   = 1'b1;
      i2c_data_r = rd;
      cycle();
      i2c_done   = 1'b0;
      i2c_data_r = 8'hEE;
      chk("err_none", 32'(ch_err), 0);
    end
    chk("done", 32'(ch_done), 32'(eg));
    chk("data_r", 32'(ch_data_r), 32'(edr));
    chk("busy_after", 32'(arb_busy), 0);
    chk("grant_idle", 32'(arb_grant), 0);
    if (rp != '0) ch_exec = rp;
    cycle();
    if (rp != '0) ch_exec = '0;
    chk("done_1pulse", 32'(ch_done), 0);
    chk("err_1pulse", 32'(ch_err), 0);
  endtask

  initial begin
    int n;
    int e0;
    logic [CH-1:0] seen;

    tbl[0] = '{0, 16'h8140, 1'b1, 1'b1, 8'h00, 8'h01,
               8'h5A, 50, 4'b0001, 8'h5A};
    tbl[1] = '{2, 16'h0012, 1'b0, 1'b0, 8'hA5, 8'h03,
               8'h33, 5, 4'b0100, 8'h33};
    tbl[2] = '{3, 16'hFFFF, 1'b1, 1'b1, 8'h3C, 8'hFF,
               8'hC3, 1, 4'b1000, 8'hC3};
    tbl[3] = '{1, 16'h1234, 1'b0, 1'b1, 8'h96, 8'h02,
               8'h11, 0, 4'b0010, 8'hC3};
    tbl[4] = '{0, 16'h0001, 1'b1, 1'b0, 8'h01, 8'h10,
               8'h77, TO, 4'b0001, 8'h77};
    tbl[5] = '{2, 16'h00A0, 1'b0, 1'b1, 8'h7E, 8'h04,
               8'h00, TO - 1, 4'b0100, 8'h00};

    for (int i = 0; i < CH; i++) begin
      ch_addr[16*i +: 16]  = 16'hA000 + 16'(i);
      ch_data_w[8*i +: 8]  = 8'hD0 + 8'(i);
      ch_reg_num[W*i +: W] = 8'hE0 + 8'(i);
    end

    cycle();
    chk("rst_busy", 32'(arb_busy), 0);
    chk("rst_grant", 32'(arb_grant), 0);
    chk("rst_exec", 32'(i2c_exec), 0);
    chk("rst_done", 32'(ch_done), 0);
    chk("rst_err", 32'(ch_err), 0);
    chk("rst_data_r", 32'(ch_data_r), 0);
    chk("rst_addr", 32'(i2c_addr), 0);
    sys_rst_n = 1'b1;
    cycle();

    for (int v = 0; v < 6; v++) begin
      ch_addr[16*tbl[v].ch +: 16]  = tbl[v].addr;
      ch_rh_wl[tbl[v].ch]          = tbl[v].rh;
      ch_bit_ctrl[tbl[v].ch]       = tbl[v].bc;
      ch_data_w[8*tbl[v].ch +: 8]  = tbl[v].dw;
      ch_reg_num[W*tbl[v].ch +: W] = tbl[v].rn;
      pulse_exec(4'(1 << tbl[v].ch));
      chk("pre_exec_low", 32'(i2c_exec), 0);
      wait_exec(5, n);
      chk("exec_latency", n, 1);
      chk("grant", 32'(arb_grant), 32'(tbl[v].eg));
      chk("i2c_addr", 32'(i2c_addr), 32'(tbl[v].addr));
      chk("i2c_rh_wl", 32'(i2c_rh_wl), 32'(tbl[v].rh));
      chk("i2c_bitc", 32'(i2c_bit_ctrl), 32'(tbl[v].bc));
      chk("i2c_dw", 32'(i2c_data_w), 32'(tbl[v].dw));
      chk("i2c_rn", 32'(i2c_reg_num), 32'(tbl[v].rn));
      serve(tbl[v].dly, tbl[v].rd, tbl[v].eg, tbl[v].edr, '0);
    end

    // Simultaneous ch0/ch1 from ptr 0
    do_reset();
    e0 = exec_cnt;
    pulse_exec(4'b0011);
    wait_exec(5, n);
    chk("dual_g0", 32'(arb_grant), 32'h1);
    serve(3, 8'h21, 4'b0001, 8'h21, '0);
    wait_exec(5, n);
    chk("dual_gap", n, 0);
    chk("dual_g1", 32'(arb_grant), 32'h2);
    serve(4, 8'h42, 4'b0010, 8'h42, '0);
    repeat (10) cycle();
    chk("dual_execs", exec_cnt - e0, 2);
    chk("dual_idle", 32'(arb_busy), 0);

    // Continuous requests from all four channels
    do_reset();
    ch_exec = 4'b1111;
    for (int t = 0; t < 8; t++) begin
      wait_exec(5, n);
      chk("rr_order", 32'(arb_grant), 32'(1 << (t % CH)));
      serve(2, 8'(t), 4'(1 << (t % CH)), 8'(t), '0);
    end
    ch_exec = '0;

    // Timeout on ch0 then ch2 served
    do_reset();
    pulse_exec(4'b0101);
    wait_exec(5, n);
    chk("to_g0", 32'(arb_grant), 32'h1);
    serve(0, 8'h00, 4'b0001, 8'h00, '0);
    wait_exec(5, n);
    chk("to_next_g", 32'(arb_grant), 32'h4);
    serve(6, 8'h99, 4'b0100, 8'h99, '0);

    // ch1 re-requests in its own ch_done cycle
    do_reset();
    pulse_exec(4'b0010);
    wait_exec(5, n);
    serve(3, 8'h12, 4'b0010, 8'h12, 4'b0010);
    wait_exec(5, n);
    chk("requeue_g", 32'(arb_grant), 32'h2);
    serve(3, 8'h34, 4'b0010, 8'h34, '0);

    // Reset in the middle of a transfer
    do_reset();
    pulse_exec(4'b0100);
    wait_exec(5, n);
    repeat (6) cycle();
    chk("mid_busy", 32'(arb_busy), 1);
    sys_rst_n = 1'b0;
    #1;
    chk("mr_busy", 32'(arb_busy), 0);
    chk("mr_grant", 32'(arb_grant), 0);
    chk("mr_addr", 32'(i2c_addr), 0);
    chk("mr_exec", 32'(i2c_exec), 0);
    cycle();
    cycle();
    sys_rst_n = 1'b1;
    seen = '0;
    for (int k = 0; k < 20; k++) begin
      i2c_done = (k == 3);
      cycle();
      seen = seen | ch_done;
      if (arb_busy) seen = seen | 4'b1000;
    end
    i2c_done = 1'b0;
    chk("mr_no_done", 32'(seen), 0);
    pulse_exec(4'b1000);
    wait_exec(5, n);
    chk("mr_fresh_g", 32'(arb_grant), 32'h8);
    serve(2, 8'hAB, 4'b1000, 8'hAB, '0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
